// File: rtl/xgmii_idle_adjust_32b.sv
// ---------------------------------------------------------------------------
// xgmii_idle_adjust_32b
//
// XGMII 32-bit idle insertion/deletion stage placed on the read side of the
// retransmit FIFO.  Words popped from the FIFO are forwarded to the TX XGMII
// through a single output register (1 cycle latency).  In the inter-packet
// gap (IPG) whole idle words are added or removed on level requests from the
// FIFO fill-level logic.  Frame contents are never modified and an IPG is
// never shrunk below MIN_IPG_WORDS idle words.
//
// Handshake: every stream interface uses valid/ready; a word moves when
// valid and ready are both high on a rising clk edge; a source holds its word
// stable while valid is high and ready is low; ready may depend
// combinationally on valid and on the request inputs.
//
// Parameters:
//   MIN_IPG_WORDS  minimum idle words kept in an IPG (deletion blocked below)
//   CNT_W          width of the saturating IPG idle-word counter
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   in_data/in_ctrl      XGMII word from FIFO (lane0 = bits [7:0] / bit 0)
//   in_valid/in_ready    input handshake
//   out_data/out_ctrl    XGMII word to TX
//   out_valid/out_ready  output handshake
//   ins_req/del_req      level requests for one idle insertion / deletion
//   ins_ack/del_ack      one-cycle pulse per idle inserted / deleted
//   proto_err            one-cycle pulse when a protocol violation is seen
//
// Optional build macro XGMII_IDLE_ADJ_STATS_EN adds:
//   clr_stats            one-cycle clear of both statistics counters
//   ins_cnt/del_cnt      16-bit saturating counts of insertions / deletions
// ---------------------------------------------------------------------------
module xgmii_idle_adjust_32b #(
    parameter int MIN_IPG_WORDS = 2,
    parameter int CNT_W         = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in_data,
    input  logic [3:0]  in_ctrl,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] out_data,
    output logic [3:0]  out_ctrl,
    output logic        out_valid,
    input  logic        out_ready,
    input  logic        ins_req,
    input  logic        del_req,
    output logic        ins_ack,
    output logic        del_ack,
    output logic        proto_err
`ifdef XGMII_IDLE_ADJ_STATS_EN
    ,
    input  logic        clr_stats,
    output logic [15:0] ins_cnt,
    output logic [15:0] del_cnt
`endif
);

    localparam logic [31:0]      IDLE_DATA = 32'h07070707;
    localparam logic [3:0]       IDLE_CTRL = 4'hF;
    localparam logic [CNT_W-1:0] MIN_IPG   = CNT_W'(MIN_IPG_WORDS);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [0:0] {
        ST_IPG = 1'b0,
        ST_PKT = 1'b1
    } state_e;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_e           state_q,     state_d;
    logic [CNT_W-1:0] ipg_cnt_q,   ipg_cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [31:0]      out_data_q,  out_data_d;
    logic [3:0]       out_ctrl_q,  out_ctrl_d;
    logic             ins_ack_q,   ins_ack_d;
    logic             del_ack_q,   del_ack_d;
    logic             proto_err_q, proto_err_d;

    // ------------------------------------------------------------------
    // Input word classification
    // ------------------------------------------------------------------
    logic is_idle;
    logic is_start;
    logic is_term;

    assign is_idle  = (in_ctrl == IDLE_CTRL) && (in_data == IDLE_DATA);
    assign is_start = (in_ctrl == 4'h1) && (in_data[7:0] == 8'hFB);

    // A terminate may sit in any lane and be followed by idle lanes; such a
    // word is a TERM and never an IDLE (lane of FD breaks the idle pattern).
    always_comb begin
        is_term = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (in_ctrl[i] && (in_data[8*i +: 8] == 8'hFD)) begin
                is_term = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Action decode
    // ------------------------------------------------------------------
    logic load_ok;
    logic in_ipg;
    logic inserting;
    logic deleting;
    logic accept;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        sat_inc = (v == {CNT_W{1'b1}}) ? v : v + CNT_ONE;
    endfunction

    always_comb begin
        load_ok = !out_valid_q || out_ready;
        in_ipg  = (state_q == ST_IPG);

        // Insertion needs at least one idle already emitted in this gap, so
        // an idle is never wedged directly behind a terminate.  It does not
        // need an input word at all.
        inserting = in_ipg && (ipg_cnt_q >= CNT_ONE) && ins_req && !del_req && load_ok;

        // Deletion swallows an input idle; it does not need the output
        // register, so it may proceed even while the output is stalled.
        deleting = in_ipg && in_valid && is_idle && del_req && !ins_req &&
                   (ipg_cnt_q >= MIN_IPG);

        in_ready = deleting || (load_ok && !inserting);
        accept   = in_valid && in_ready;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        ipg_cnt_d   = ipg_cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ctrl_d  = out_ctrl_q;
        ins_ack_d   = 1'b0;
        del_ack_d   = 1'b0;
        proto_err_d = 1'b0;

        if (inserting) begin
            out_valid_d = 1'b1;
            out_data_d  = IDLE_DATA;
            out_ctrl_d  = IDLE_CTRL;
            ins_ack_d   = 1'b1;
            ipg_cnt_d   = sat_inc(ipg_cnt_q);
        end else if (deleting) begin
            // The gap length seen downstream is unchanged by a removed idle,
            // so the counter holds.  A drained output simply goes empty.
            del_ack_d = 1'b1;
            if (load_ok) begin
                out_valid_d = 1'b0;
            end
        end else if (load_ok) begin
            out_valid_d = accept;
            if (accept) begin
                out_data_d = in_data;
                out_ctrl_d = in_ctrl;
                unique case (state_q)
                    ST_IPG: begin
                        if (is_start) begin
                            state_d = ST_PKT;
                        end else if (is_idle) begin
                            ipg_cnt_d = sat_inc(ipg_cnt_q);
                        end else begin
                            // Data/terminate/other inside the gap: passed on
                            // untouched, flagged, and not counted as idle.
                            proto_err_d = 1'b1;
                        end
                    end
                    ST_PKT: begin
                        if (is_term) begin
                            state_d   = ST_IPG;
                            ipg_cnt_d = '0;
                        end else if (is_start) begin
                            proto_err_d = 1'b1;
                        end
                    end
                    default: begin
                        state_d = ST_IPG;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IPG;
            ipg_cnt_q   <= MIN_IPG;
            out_valid_q <= 1'b0;
            out_data_q  <= IDLE_DATA;
            out_ctrl_q  <= IDLE_CTRL;
            ins_ack_q   <= 1'b0;
            del_ack_q   <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ipg_cnt_q   <= ipg_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ctrl_q  <= out_ctrl_d;
            ins_ack_q   <= ins_ack_d;
            del_ack_q   <= del_ack_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ctrl  = out_ctrl_q;
    assign ins_ack   = ins_ack_q;
    assign del_ack   = del_ack_q;
    assign proto_err = proto_err_q;

`ifdef XGMII_IDLE_ADJ_STATS_EN
    // ------------------------------------------------------------------
    // Statistics: counts move in the same cycle the matching ack rises.
    // ------------------------------------------------------------------
    logic [15:0] ins_cnt_q, ins_cnt_d;
    logic [15:0] del_cnt_q, del_cnt_d;

    always_comb begin
        ins_cnt_d = ins_cnt_q;
        del_cnt_d = del_cnt_q;
        if (clr_stats) begin
            ins_cnt_d = 16'h0000;
            del_cnt_d = 16'h0000;
        end else begin
            if (ins_ack_d && (ins_cnt_q != 16'hFFFF)) begin
                ins_cnt_d = ins_cnt_q + 16'd1;
            end
            if (del_ack_d && (del_cnt_q != 16'hFFFF)) begin
                del_cnt_d = del_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ins_cnt_q <= 16'h0000;
            del_cnt_q <= 16'h0000;
        end else begin
            ins_cnt_q <= ins_cnt_d;
            del_cnt_q <= del_cnt_d;
        end
    end

    assign ins_cnt = ins_cnt_q;
    assign del_cnt = del_cnt_q;
`endif

endmodule
